// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity receive path.
package serial_parity_pkg;
  typedef enum logic [1:0] {S_DATA, S_PAR, S_HOLD} sp_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/serial_xor_acc.sv
// One-bit running XOR accumulator: clear wins over enable.
module serial_xor_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_d,
  output logic o_acc
);
  logic r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_acc <= 1'b0;
    else if (i_clr) r_acc <= 1'b0;
    else if (i_en)  r_acc <= r_acc ^ i_d;
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises DATA_W LSB-first bits plus a parity bit and flags parity mismatches.
module serial_parity_checker
  import serial_parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bit,
  input  logic              frame_abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  sp_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_err;
  logic              w_take, w_abort, w_last, w_acc, w_acc_clr, w_acc_en;
  logic              w_par_tgt;

  assign w_par_tgt = ODD_PARITY ? PAR_ODD : PAR_EVEN;
  assign w_last    = (r_cnt == CNT_W'(DATA_W - 1));
  // Abort is only honoured while a frame is being assembled; a held result always drains.
  assign w_abort   = frame_abort && (r_state != S_HOLD);
  assign w_acc_en  = w_take && (r_state == S_DATA);
  assign w_acc_clr = w_abort || (w_take && (r_state == S_PAR));

  serial_xor_acc u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_acc_clr),
    .i_en  (w_acc_en),
    .i_d   (in_bit),
    .o_acc (w_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_DATA;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_DATA;
    end else begin
      case (r_state)
        S_DATA:  if (w_take && w_last) w_state_nxt = S_PAR;
        S_PAR:   if (w_take)           w_state_nxt = S_HOLD;
        S_HOLD:  if (out_ready)        w_state_nxt = S_DATA;
        default:                       w_state_nxt = S_DATA;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state != S_HOLD) && !frame_abort;
    out_valid = (r_state == S_HOLD);
    w_take    = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (w_abort) begin
      r_cnt <= '0;
    end else if (w_acc_en) begin
      r_shreg[r_cnt] <= in_bit;
      r_cnt          <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_err  <= 1'b0;
    end else if (w_take && (r_state == S_PAR)) begin
      r_out_data <= r_shreg;
      r_out_err  <= ((w_acc ^ in_bit) != w_par_tgt);
    end
  end

  assign out_data = r_out_data;
  assign out_err  = r_out_err;
endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: even and odd parity instances driven in lockstep.
module tb_serial_parity_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, in_bit, frame_abort, out_ready;
  logic       in_ready_e, out_valid_e, out_err_e;
  logic       in_ready_o, out_valid_o, out_err_o;
  logic [7:0] out_data_e, out_data_o;

  int checks   = 0;
  int failures = 0;

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1'b0)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_e), .in_bit(in_bit),
    .frame_abort(frame_abort), .out_valid(out_valid_e), .out_ready(out_ready),
    .out_data(out_data_e), .out_err(out_err_e));

  serial_parity_checker #(.DATA_W(8), .ODD_PARITY(1'b1)) dut_o (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o), .in_bit(in_bit),
    .frame_abort(frame_abort), .out_valid(out_valid_o), .out_ready(out_ready),
    .out_data(out_data_o), .out_err(out_err_o));

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic [7:0] exp_data;
    logic       exp_err_e;
    logic       exp_err_o;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the bit was accepted.
  task automatic send_bit(input logic b);
    int n = 0;
    while (!in_ready_e && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_bit_timeout actual=in_ready_low required=in_ready_high");
    end
    in_valid = 1'b1;
    in_bit   = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int lo, input int hi);
    int g = $urandom_range(hi, lo);
    repeat (g) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input int lo, input int hi);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      idle(lo, hi);
    end
    send_bit(p);
  endtask

  task automatic check_result(input string name, input logic [7:0] d, input logic ee, input logic eo);
    chk({name, "_valid_e"}, 32'(out_valid_e), 32'd1);
    chk({name, "_valid_o"}, 32'(out_valid_o), 32'd1);
    chk({name, "_data_e"},  32'(out_data_e),  32'(d));
    chk({name, "_data_o"},  32'(out_data_o),  32'(d));
    chk({name, "_err_e"},   32'(out_err_e),   32'(ee));
    chk({name, "_err_o"},   32'(out_err_o),   32'(eo));
  endtask

  task automatic retire(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_retired"}, 32'(out_valid_e | out_valid_o), 32'd0);
    chk({name, "_ready_after"}, 32'(in_ready_e), 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    logic [7:0] rd;
    logic       rp, ee, eo;
    int         k;

    vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0, 1'b1};
    vecs[1] = '{8'h01, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h7E, 1'b1, 8'h7E, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; frame_abort = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(out_valid_e), 32'd0);
    chk("reset_data",  32'(out_data_e),  32'd0);
    chk("reset_err",   32'(out_err_e),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready_e), 32'd1);

    // Latency: result not visible before the parity edge, visible right after it.
    for (int i = 0; i < 8; i++) send_bit(vecs[0].data[i]);
    chk("lat_before_par", 32'(out_valid_e), 32'd0);
    send_bit(1'b0);
    check_result("lat_a5", 8'hA5, 1'b0, 1'b1);
    retire("lat_a5");

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, vecs[v].par, 0, 0);
      check_result($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_err_e, vecs[v].exp_err_o);
      retire($sformatf("vec%0d", v));
    end

    // Backpressure: result held, input stalled.
    send_frame(8'h01, 1'b0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_in_ready_c%0d", c), 32'(in_ready_e), 32'd0);
      chk($sformatf("bp_data_c%0d", c), 32'(out_data_e), 32'h01);
      @(negedge clk);
    end
    retire("bp");
    send_frame(8'hFF, 1'b0, 0, 0);
    check_result("bp_next", 8'hFF, 1'b0, 1'b1);
    retire("bp_next");

    send_frame(8'h3C, 1'b0, 1, 3);
    check_result("gaps", 8'h3C, 1'b0, 1'b1);
    retire("gaps");

    // Abort with a bit presented in the same cycle: that bit must be dropped.
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    frame_abort = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready_e), 32'd0);
    @(negedge clk);
    frame_abort = 1'b0; in_valid = 1'b0;
    send_frame(8'h0F, 1'b0, 0, 0);
    check_result("abort", 8'h0F, 1'b0, 1'b1);
    retire("abort");

    // Abort while holding a result is ignored.
    send_frame(8'h5A, 1'b0, 0, 0);
    frame_abort = 1'b1;
    @(negedge clk);
    frame_abort = 1'b0;
    check_result("abort_hold", 8'h5A, 1'b0, 1'b1);
    retire("abort_hold");

    // Reset mid-frame clears outputs left by the previous frame.
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid_e), 32'd0);
    chk("rst_mid_data",  32'(out_data_e),  32'd0);
    chk("rst_mid_err",   32'(out_err_e),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(8'h80, 1'b1, 0, 0);
    check_result("rst_mid_after", 8'h80, 1'b0, 1'b1);
    retire("rst_mid_after");

    // Random frames, sometimes preceded by an aborted partial frame.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(4, 0) == 0) begin
        k = $urandom_range(7, 1);
        for (int i = 0; i < k; i++) send_bit(1'($urandom_range(1, 0)));
        frame_abort = 1'b1; in_valid = 1'b1; in_bit = 1'($urandom_range(1, 0));
        @(negedge clk);
        frame_abort = 1'b0; in_valid = 1'b0;
      end
      rd = 8'($urandom_range(255, 0));
      rp = 1'($urandom_range(1, 0));
      ee = ((^rd) ^ rp) != 1'b0;
      eo = ((^rd) ^ rp) != 1'b1;
      send_frame(rd, rp, 0, 2);
      k = $urandom_range(3, 0);
      repeat (k) @(negedge clk);
      check_result($sformatf("rnd%0d", f), rd, ee, eo);
      retire($sformatf("rnd%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
